hilo_unit: RTL and testbench

Owns the architectural HI/LO register pair and the multi-cycle multiply/divide engine behind it. The decode-stage HI/LO write descriptor is produced elsewhere; this block consumes it at commit and serves MFHI/MFLO reads. It sits beside the execute/writeback stages. It accepts MULT/MULTU/DIV/DIVU requests over a valid/ready handshake, stalls the pipeline via `busy`, and writes the 64-bit result into HI/LO on completion.

---
 rtl/hilo_unit_pkg.sv | 27 ++
 rtl/hilo_divider.sv | 67 ++++++
 rtl/hilo_unit.sv | 146 ++++++++++++++
 tb/tb_hilo_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared types for the HI/LO unit: pipeline op codes, direct-write descriptor,
// engine state encoding and the default divider iteration count.
package mycpu;

   localparam int DIV_ITERS_DEFAULT = 32;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_ALU   = 3'd5
   } op_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } write_hilo_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } hilo_state_t;

endpackage

// File: rtl/hilo_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// quotient/remainder show the next-state value so the final bit is usable in the done cycle.
module hilo_divider
   import mycpu::*;
#(
   parameter int ITERS = DIV_ITERS_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   logic          active_reg;
   logic [CW-1:0] cnt_reg;
   logic [31:0]   rem_reg;
   logic [31:0]   quo_reg;
   logic [31:0]   dvs_reg;

   logic [32:0]   shifted;
   logic [32:0]   diff;
   logic [31:0]   rem_next;
   logic [31:0]   quo_next;

   // Partial remainder stays below the divisor, so diff[32] is a clean borrow flag.
   assign shifted  = {rem_reg, quo_reg[31]};
   assign diff     = shifted - {1'b0, dvs_reg};
   assign rem_next = diff[32] ? shifted[31:0] : diff[31:0];
   assign quo_next = {quo_reg[30:0], ~diff[32]};

   assign quotient  = quo_next;
   assign remainder = rem_next;
   assign done      = active_reg && (cnt_reg == CW'(ITERS - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         active_reg <= 1'b0;
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         dvs_reg    <= '0;
      end else if (start) begin
         active_reg <= 1'b1;
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quo_reg    <= dividend;
         dvs_reg    <= divisor;
      end else if (active_reg) begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
         if (done) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with multi-cycle MULT/MULTU/DIV/DIVU engine.
// Define HILO_FORWARD_EN to bypass direct writes combinationally onto rd_hi/rd_lo.
module hilo_unit
   import mycpu::*;
#(
   parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  op_t         req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        cancel,
   input  logic        wr_hi_en,
   input  logic        wr_lo_en,
   input  write_hilo_t wr_hilo,
   output logic        busy,
   output logic [31:0] rd_hi,
   output logic [31:0] rd_lo
);

   hilo_state_t state_reg;
   op_t         op_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   logic        accept;
   logic        is_mul_op;
   logic        is_div_op;
   logic        div_signed_req;
   logic [31:0] dvd_abs;
   logic [31:0] dvs_abs;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;
   logic        div_done;

   logic        mul_signed;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic        neg_q;
   logic        neg_r;
   logic        eng_we;
   logic [31:0] eng_hi;
   logic [31:0] eng_lo;

   assign req_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);

   assign is_mul_op = (req_op == OP_MULT) || (req_op == OP_MULTU);
   assign is_div_op = (req_op == OP_DIV)  || (req_op == OP_DIVU);
   assign accept    = req_valid && req_ready && !cancel;

   // The core only sees magnitudes; signs are reapplied at completion.
   assign div_signed_req = (req_op == OP_DIV);
   assign dvd_abs = (div_signed_req && req_a[31]) ? -req_a : req_a;
   assign dvs_abs = (div_signed_req && req_b[31]) ? -req_b : req_b;

   hilo_divider #(
      .ITERS(DIV_ITERS)
   ) u_divider (
      .clk      (clk),
      .reset    (reset),
      .clear    (cancel),
      .start    (accept && is_div_op),
      .dividend (dvd_abs),
      .divisor  (dvs_abs),
      .quotient (div_quotient),
      .remainder(div_remainder),
      .done     (div_done)
   );

   // Low 64 bits of a 64x64 product of extended operands equal the 32x32 result.
   assign mul_signed = (op_reg == OP_MULT);
   assign mul_a   = {{32{mul_signed && a_reg[31]}}, a_reg};
   assign mul_b   = {{32{mul_signed && b_reg[31]}}, b_reg};
   assign product = mul_a * mul_b;

   assign neg_q  = (op_reg == OP_DIV) && (a_reg[31] ^ b_reg[31]);
   assign neg_r  = (op_reg == OP_DIV) && a_reg[31];
   assign eng_we = !cancel && ((state_reg == MUL) || ((state_reg == DIV) && div_done));

   always_comb begin
      eng_hi = product[63:32];
      eng_lo = product[31:0];
      if (state_reg == DIV) begin
         if (b_reg == '0) begin
            eng_hi = a_reg;
            eng_lo = '1;
         end else begin
            eng_hi = neg_r ? -div_remainder : div_remainder;
            eng_lo = neg_q ? -div_quotient  : div_quotient;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         op_reg    <= OP_NOP;
         a_reg     <= '0;
         b_reg     <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         // Direct writes take precedence over the engine for their half.
         if (wr_hi_en)    hi_reg <= wr_hilo.hi;
         else if (eng_we) hi_reg <= eng_hi;
         if (wr_lo_en)    lo_reg <= wr_hilo.lo;
         else if (eng_we) lo_reg <= eng_lo;

         if (accept && (is_mul_op || is_div_op)) begin
            op_reg <= req_op;
            a_reg  <= req_a;
            b_reg  <= req_b;
         end

         if (cancel) begin
            state_reg <= IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (accept && is_mul_op)      state_reg <= MUL;
                  else if (accept && is_div_op) state_reg <= DIV;
               end
               MUL:     state_reg <= IDLE;
               DIV:     if (div_done) state_reg <= IDLE;
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

`ifdef HILO_FORWARD_EN
   assign rd_hi = wr_hi_en ? wr_hilo.hi : hi_reg;
   assign rd_lo = wr_lo_en ? wr_hilo.lo : lo_reg;
`else
   assign rd_hi = hi_reg;
   assign rd_lo = lo_reg;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed corner cases plus randomized
// op sequences checked against an arithmetic reference model.
module tb_hilo_unit;
   import mycpu::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   op_t         req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        cancel;
   logic        wr_hi_en;
   logic        wr_lo_en;
   write_hilo_t wr_hilo;
   logic        busy;
   logic [31:0] rd_hi;
   logic [31:0] rd_lo;

   int checks = 0;
   int errors = 0;
   bit [31:0] hi_m = 0;
   bit [31:0] lo_m = 0;

   hilo_unit #(.DIV_ITERS(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_a    (req_a),
      .req_b    (req_b),
      .cancel   (cancel),
      .wr_hi_en (wr_hi_en),
      .wr_lo_en (wr_lo_en),
      .wr_hilo  (wr_hilo),
      .busy     (busy),
      .rd_hi    (rd_hi),
      .rd_lo    (rd_lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: {hi, lo} computed from the architectural definitions.
   function automatic bit [63:0] ref_result(input op_t op, input bit [31:0] a, input bit [31:0] b);
      longint sp;
      bit [63:0] up;
      int qa, qb;
      case (op)
         OP_MULT: begin
            sp = longint'(int'(a)) * longint'(int'(b));
            return sp;
         end
         OP_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            return up;
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (op == OP_DIVU) return {a % b, a / b};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            qa = int'(a);
            qb = int'(b);
            return {32'(qa % qb), 32'(qa / qb)};
         end
      endcase
   endfunction

   task automatic issue(input op_t op, input bit [31:0] a, input bit [31:0] b);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      check("req_ready_idle", {63'd0, req_ready}, 64'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic run_op(input op_t op, input bit [31:0] a, input bit [31:0] b);
      int n;
      bit [63:0] r;
      issue(op, a, b);
      n = 0;
      while (busy && n < 100) begin
         n++;
         step();
      end
      r = ref_result(op, a, b);
      hi_m = r[63:32];
      lo_m = r[31:0];
      check("busy_cycles", 64'(n), (op == OP_MULT || op == OP_MULTU) ? 64'd1 : 64'd32);
      check("result_hilo", {rd_hi, rd_lo}, {hi_m, lo_m});
      $display("op %s a=%h b=%h busy=%0d -> hi=%h lo=%h", op.name(), a, b, n, rd_hi, rd_lo);
   endtask

   initial begin
      op_t ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
      bit [31:0] a, b, w;
      int k;

      reset = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_a = 0; req_b = 0;
      cancel = 1'b0; wr_hi_en = 1'b0; wr_lo_en = 1'b0; wr_hilo = '0;
      step(); step();
      reset = 1'b0;
      check("reset_hilo", {rd_hi, rd_lo}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_ready", {63'd0, req_ready}, 64'd1);

      run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3);
      check("mult_plan", {rd_hi, rd_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
      run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
      check("multu_plan", {rd_hi, rd_lo}, {32'h0000_0002, 32'hFFFF_FFFA});
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
      check("div_neg_plan", {rd_hi, rd_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(OP_DIVU,  32'd100, 32'd0);
      check("divu_zero_plan", {rd_hi, rd_lo}, {32'd100, 32'hFFFF_FFFF});
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf_plan", {rd_hi, rd_lo}, {32'd0, 32'h8000_0000});
      run_op(OP_DIV,   32'd7, 32'd0);

      // Direct HI write in the divider's completion cycle
      issue(OP_DIV, 32'd10, 32'd3);
      repeat (31) step();
      check("busy_at_t32", {63'd0, busy}, 64'd1);
      wr_hi_en = 1'b1; wr_hilo.hi = 32'h55; wr_hilo.lo = 32'hDEAD;
      step();
      wr_hi_en = 1'b0;
      hi_m = 32'h55; lo_m = 32'd3;
      check("wr_vs_complete", {rd_hi, rd_lo}, {hi_m, lo_m});
      $display("div+wr_hi hi=%h lo=%h", rd_hi, rd_lo);

      // Cancel at t+10
      issue(OP_DIV, 32'd1000, 32'd7);
      repeat (9) step();
      check("busy_before_cancel", {63'd0, busy}, 64'd1);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("cancel_idle", {62'd0, busy, req_ready}, 64'd1);
      repeat (30) step();
      check("cancel_no_update", {rd_hi, rd_lo}, {hi_m, lo_m});
      $display("cancel hi=%h lo=%h", rd_hi, rd_lo);

      // Cancel suppresses a same-cycle accept
      req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd9; req_b = 32'd9; cancel = 1'b1;
      step();
      req_valid = 1'b0; cancel = 1'b0;
      step();
      check("cancel_blocks_accept", {31'd0, busy, rd_hi, rd_lo}, {32'd0, hi_m, lo_m});

      // Reset mid-operation
      issue(OP_DIVU, 32'hFFFF_0000, 32'd5);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      hi_m = 0; lo_m = 0;
      check("reset_midop", {31'd0, busy, rd_hi, rd_lo}, 64'd0);
      repeat (30) step();
      check("reset_no_late_write", {rd_hi, rd_lo}, 64'd0);
      $display("reset mid-op hi=%h lo=%h", rd_hi, rd_lo);

      // Direct LO write visibility
      wr_lo_en = 1'b1; wr_hilo.lo = 32'h1234;
      #1;
`ifdef HILO_FORWARD_EN
      check("fwd_same_cycle", {32'd0, rd_lo}, 64'h1234);
`else
      check("nofwd_same_cycle", {32'd0, rd_lo}, {32'd0, lo_m});
`endif
      step();
      wr_lo_en = 1'b0;
      lo_m = 32'h1234;
      check("wr_lo_next_cycle", {rd_hi, rd_lo}, {hi_m, lo_m});
      $display("wr_lo hi=%h lo=%h", rd_hi, rd_lo);

      // Randomized sequence
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) b = 0;
         if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
         if (k == 0) begin
            req_valid = 1'b1; req_op = ($urandom_range(0, 1) == 0) ? OP_NOP : OP_ALU;
            req_a = a; req_b = b;
            step();
            req_valid = 1'b0;
            check("drop_bad_op", {31'd0, busy, rd_hi, rd_lo}, {32'd0, hi_m, lo_m});
            $display("drop op %s hi=%h lo=%h", req_op.name(), rd_hi, rd_lo);
         end else if (k == 1) begin
            w = $urandom;
            wr_hi_en = $urandom_range(0, 1) == 1;
            wr_lo_en = $urandom_range(0, 1) == 1;
            wr_hilo.hi = a; wr_hilo.lo = w;
            step();
            if (wr_hi_en) hi_m = a;
            if (wr_lo_en) lo_m = w;
            wr_hi_en = 1'b0; wr_lo_en = 1'b0;
            check("rand_direct_wr", {rd_hi, rd_lo}, {hi_m, lo_m});
            $display("direct wr hi=%h lo=%h", rd_hi, rd_lo);
         end else begin
            run_op(ops[$urandom_range(0, 3)], a, b);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
